// File: rtl/i2c_target_if.sv
// i2c_target_if: pad-side bus and host-side byte interface of the I2C target.
interface i2c_target_if;
    logic       enable;
    logic [6:0] own_addr;
    logic       scl_in;
    logic       sda_in;
    logic       sda_out;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       rw;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    logic       nack_det;
    modport slave (
        input  enable, own_addr, scl_in, sda_in, tx_data,
        output sda_out, sda_oe, rx_data, rx_valid, tx_load, rw, busy, start_det, stop_det, nack_det
    );
    modport master (
        output enable, own_addr, scl_in, sda_in, tx_data,
        input  sda_out, sda_oe, rx_data, rx_valid, tx_load, rw, busy, start_det, stop_det, nack_det
    );
endinterface

// File: rtl/i2c_target.sv
// i2c_target: I2C target responder; matches a 7-bit address, ACKs, receives write bytes and serializes read bytes.
module i2c_target #(
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    i2c_target_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_p, sda_p, scl_s, sda_s, rise, fall, start, stop, match;
    logic [2:0] cnt, cnt_n;
    logic [6:0] sh, sh_n;
    logic [7:0] rx_data, rx_data_n;
    logic oe, oe_n, rw, rw_n, busy, busy_n, tx_load;
    logic rx_valid, rx_valid_n, start_det, start_n, stop_det, stop_n, nack_det, nack_n;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
    assign rise  = ~scl_p & scl_s;
    assign fall  = scl_p & ~scl_s;
    // SCL must be high in both samples, so an SDA change beside an SCL edge is data
    assign start = scl_p & scl_s & sda_p & ~sda_s;
    assign stop  = scl_p & scl_s & ~sda_p & sda_s;
    assign match = (sh == bus.own_addr) && (bus.own_addr != 7'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_p     <= 1'b1;
            sda_p     <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            oe        <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_p     <= scl_s;
            sda_p     <= sda_s;
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            rx_data   <= rx_data_n;
            oe        <= oe_n;
            rw        <= rw_n;
            busy      <= busy_n;
            rx_valid  <= rx_valid_n;
            start_det <= start_n;
            stop_det  <= stop_n;
            nack_det  <= nack_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sh_n       = sh;
        rx_data_n  = rx_data;
        oe_n       = oe;
        rw_n       = rw;
        busy_n     = busy;
        rx_valid_n = 1'b0;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        nack_n     = 1'b0;
        tx_load    = 1'b0;
        if (rst || !bus.enable) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            start_n = 1'b1;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            stop_n  = 1'b1;
        end else begin
            case (state)
                ADDR, RX_DATA: if (rise) begin
                    sh_n  = {sh[5:0], sda_s};
                    cnt_n = cnt + 3'd1;
                    if (cnt == 3'd7 && state == ADDR) begin
                        rw_n    = sda_s;
                        busy_n  = match;
                        state_n = match ? ADDR_ACK : WAIT_STOP;
                    end else if (cnt == 3'd7) begin
                        rx_data_n  = {sh, sda_s};
                        rx_valid_n = 1'b1;
                        state_n    = RX_ACK;
                    end
                end
                // first falling edge drives the ACK, the next one ends the ACK slot
                ADDR_ACK, RX_ACK: if (fall) begin
                    if (!oe) begin
                        oe_n = 1'b1;
                    end else if (state == ADDR_ACK && rw) begin
                        tx_load = 1'b1;
                        sh_n    = bus.tx_data[6:0];
                        oe_n    = ~bus.tx_data[7];
                        cnt_n   = '0;
                        state_n = TX_DATA;
                    end else begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = RX_DATA;
                    end
                end
                TX_DATA: if (fall) begin
                    oe_n    = (cnt == 3'd7) ? 1'b0 : ~sh[6];
                    sh_n    = {sh[5:0], 1'b0};
                    cnt_n   = cnt + 3'd1;
                    state_n = (cnt == 3'd7) ? TX_ACK : TX_DATA;
                end
                TX_ACK: if (rise && sda_s) begin
                    nack_n  = 1'b1;
                    state_n = WAIT_STOP;
                end else if (fall) begin
                    tx_load = 1'b1;
                    sh_n    = bus.tx_data[6:0];
                    oe_n    = ~bus.tx_data[7];
                    cnt_n   = '0;
                    state_n = TX_DATA;
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_out   = 1'b0;
    assign bus.sda_oe    = oe;
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.tx_load   = tx_load;
    assign bus.rw        = rw;
    assign bus.busy      = busy;
    assign bus.start_det = start_det;
    assign bus.stop_det  = stop_det;
    assign bus.nack_det  = nack_det;
endmodule
